// File: rtl/vcve2_vrf_if_sequencer_if.sv
// Handshake and status bundle between the vector control path and vcve2_vrf_if_sequencer.
// The perf counter signals exist only when VCVE2_SEQ_PERF_EN is defined.
interface vcve2_vrf_if_sequencer_if #(
    parameter int unsigned NumIfs = 3,
    parameter int unsigned BeatW  = 8
);
    logic              req;
    logic              gnt;
    logic [BeatW-1:0]  num_beats;
    logic [NumIfs-1:0] active_mask;
    logic              kill;
    logic [NumIfs-1:0] if_start;
    logic [NumIfs-1:0] if_done;
    logic [NumIfs-1:0] if_err;
    logic              agu_load;
    logic              agu_incr;
    logic [BeatW-1:0]  beat_idx;
    logic              busy;
    logic              vector_done;
    logic              err;
`ifdef VCVE2_SEQ_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_beats;
`endif

    modport master (
        output req, num_beats, active_mask, kill, if_done, if_err,
        input  gnt, if_start, agu_load, agu_incr, beat_idx, busy, vector_done, err
`ifdef VCVE2_SEQ_PERF_EN
        , input perf_stall_cnt, perf_beats
`endif
    );

    modport slave (
        input  req, num_beats, active_mask, kill, if_done, if_err,
        output gnt, if_start, agu_load, agu_incr, beat_idx, busy, vector_done, err
`ifdef VCVE2_SEQ_PERF_EN
        , output perf_stall_cnt, perf_beats
`endif
    );
endinterface

// File: rtl/vcve2_vrf_if_sequencer.sv
// Sequencer for N VRF interface FSMs: staggered starts, per-beat done barrier, AGU control.
// Optional perf counters are compiled in with VCVE2_SEQ_PERF_EN.
module vcve2_vrf_if_sequencer #(
    parameter int unsigned NumIfs        = 3,
    parameter int unsigned StaggerCycles = 1,
    parameter int unsigned BeatW         = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    vcve2_vrf_if_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4
    } state_e;

    localparam logic [5:0] LastCnt = 6'((NumIfs - 1) * StaggerCycles);

    state_e            state_r, state_s;
    logic [5:0]        cnt_r;
    logic [BeatW-1:0]  nb_r, beat_r;
    logic [NumIfs-1:0] mask_r, done_r, start_s;
    logic              incr_r, last_r, rdy_r;
    logic              gnt_s, armed_s, launch_last_s, comp_s, err_hit_s, fire_s, final_s;

    // Barrier evaluation, grant and next-state selection
    always_comb begin
        gnt_s         = (state_r == ST_IDLE) && rdy_r && bus.req;
        armed_s       = (state_r == ST_LAUNCH) || (state_r == ST_RUN);
        launch_last_s = (state_r == ST_LAUNCH) && (cnt_r == LastCnt);
        comp_s        = ((done_r | bus.if_done) & mask_r) == mask_r;
        err_hit_s     = armed_s && (|(bus.if_err & mask_r));
        final_s       = incr_r && last_r;
        // A completion seen during LAUNCH stays sticky in done_r and fires on the final LAUNCH cycle
        fire_s        = comp_s && !bus.kill && !err_hit_s &&
                        (((state_r == ST_RUN) && !final_s) || launch_last_s);
        state_s       = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s) begin
                    if ((bus.num_beats == {BeatW{1'b0}}) || (bus.active_mask == {NumIfs{1'b0}})) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (bus.kill)          state_s = ST_IDLE;
                else if (err_hit_s)    state_s = ST_ABORT;
                else if (launch_last_s) state_s = ST_RUN;
                else                   state_s = ST_LAUNCH;
            end
            ST_RUN: begin
                if (bus.kill)       state_s = ST_IDLE;
                else if (err_hit_s) state_s = ST_ABORT;
                else if (final_s)   state_s = ST_DONE;
                else                state_s = ST_RUN;
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ABORT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Instruction context, stagger counter, barrier and beat bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_r  <= 1'b0;
            nb_r   <= {BeatW{1'b0}};
            mask_r <= {NumIfs{1'b0}};
            cnt_r  <= 6'd0;
            done_r <= {NumIfs{1'b0}};
            beat_r <= {BeatW{1'b0}};
            incr_r <= 1'b0;
            last_r <= 1'b0;
        end else begin
            rdy_r  <= 1'b1;
            incr_r <= fire_s;
            last_r <= fire_s && (beat_r == (nb_r - {{(BeatW-1){1'b0}}, 1'b1}));
            if (gnt_s) begin
                nb_r   <= bus.num_beats;
                mask_r <= bus.active_mask;
                cnt_r  <= 6'd0;
                done_r <= {NumIfs{1'b0}};
                beat_r <= {BeatW{1'b0}};
            end else begin
                if ((state_r == ST_LAUNCH) && !launch_last_s) begin
                    cnt_r <= cnt_r + 6'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
                if (fire_s) begin
                    done_r <= {NumIfs{1'b0}};
                    beat_r <= beat_r + {{(BeatW-1){1'b0}}, 1'b1};
                end else if (armed_s) begin
                    done_r <= done_r | (bus.if_done & mask_r);
                end else begin
                    done_r <= {NumIfs{1'b0}};
                end
            end
        end
    end

    // Per-interface start slots during LAUNCH
    always_comb begin
        start_s = {NumIfs{1'b0}};
        for (int i = 0; i < NumIfs; i++) begin
            if ((state_r == ST_LAUNCH) && (cnt_r == 6'(i * StaggerCycles)) && mask_r[i]) begin
                start_s[i] = 1'b1;
            end else begin
                start_s[i] = 1'b0;
            end
        end
    end

    assign bus.gnt         = gnt_s;
    assign bus.agu_load    = gnt_s;
    assign bus.if_start    = start_s;
    assign bus.agu_incr    = incr_r;
    assign bus.beat_idx    = beat_r;
    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.vector_done = (state_r == ST_DONE) && !bus.kill;
    assign bus.err         = (state_r == ST_ABORT);

`ifdef VCVE2_SEQ_PERF_EN
    logic [31:0] stall_r, beats_r;

    // Saturating perf counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_r <= 32'd0;
            beats_r <= 32'd0;
        end else begin
            if ((state_r == ST_RUN) && !comp_s && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end else begin
                stall_r <= stall_r;
            end
            if (incr_r && (beats_r != 32'hFFFF_FFFF)) begin
                beats_r <= beats_r + 32'd1;
            end else begin
                beats_r <= beats_r;
            end
        end
    end

    assign bus.perf_stall_cnt = stall_r;
    assign bus.perf_beats     = beats_r;
`endif
endmodule

// File: tb/tb_vcve2_vrf_if_sequencer.sv
// Directed self-checking bench for vcve2_vrf_if_sequencer (NumIfs=3, StaggerCycles=1, BeatW=8).
module tb_vcve2_vrf_if_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   incr_cnt = 0;
    int   start_cnt = 0;
    int   base_incr, base_start;

    always #5 clk = ~clk;

    vcve2_vrf_if_sequencer_if #(.NumIfs(3), .BeatW(8)) bus ();

    vcve2_vrf_if_sequencer #(.NumIfs(3), .StaggerCycles(1), .BeatW(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always @(negedge clk) begin
        if (bus.agu_incr) incr_cnt <= incr_cnt + 1;
        if (|bus.if_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [2:0] d, input logic [2:0] e, input logic k);
        @(posedge clk);
        #1;
        bus.req = r; bus.if_done = d; bus.if_err = e; bus.kill = k;
        #1;
    endtask

    task automatic accept(input logic [7:0] nb, input logic [2:0] m);
        bus.num_beats = nb; bus.active_mask = m;
        drv(1'b1, 3'b000, 3'b000, 1'b0);
        chk("gnt", 32'(bus.gnt), 32'd1);
        chk("agu_load", 32'(bus.agu_load), 32'd1);
    endtask

    task automatic launch3(input string tag, input logic [2:0] m);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk({tag, "_start0"}, 32'(bus.if_start), 32'(m & 3'b001));
        chk({tag, "_load_once"}, 32'(bus.agu_load), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk({tag, "_start1"}, 32'(bus.if_start), 32'(m & 3'b010));
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk({tag, "_start2"}, 32'(bus.if_start), 32'(m & 3'b100));
    endtask

    initial begin
        bus.req = 1'b1; bus.num_beats = 8'd0; bus.active_mask = 3'b000;
        bus.kill = 1'b0; bus.if_done = 3'b000; bus.if_err = 3'b000;
        #12;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_beat", 32'(bus.beat_idx), 32'd0);
        chk("rst_start", 32'(bus.if_start), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; bus.req = 1'b0;

        // Basic stagger, nb=2, all dones together
        accept(8'd2, 3'b111);
        chk("basic_busy_idle", 32'(bus.busy), 32'd0);
        launch3("basic", 3'b111);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_run_nostart", 32'(bus.if_start), 32'd0);
        drv(1'b0, 3'b111, 3'b000, 1'b0); chk("basic_incr_t", 32'(bus.agu_incr), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_incr0", 32'(bus.agu_incr), 32'd1);
        chk("basic_beat1", 32'(bus.beat_idx), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_incr_gap", 32'(bus.agu_incr), 32'd0);
        drv(1'b0, 3'b111, 3'b000, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_incr1", 32'(bus.agu_incr), 32'd1);
        chk("basic_vdone_early", 32'(bus.vector_done), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_vdone", 32'(bus.vector_done), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("basic_idle", 32'(bus.busy), 32'd0);
        chk("basic_vdone_pulse", 32'(bus.vector_done), 32'd0);

        // Masked interface 1, nb=1
        accept(8'd1, 3'b101);
        launch3("mask", 3'b101);
        drv(1'b0, 3'b101, 3'b000, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("mask_incr", 32'(bus.agu_incr), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("mask_vdone", 32'(bus.vector_done), 32'd1);

        // Skewed dones for beat 0, then kill during beat 1
        drv(1'b0, 3'b000, 3'b000, 1'b0);
        accept(8'd2, 3'b111);
        launch3("skew", 3'b111);
        drv(1'b0, 3'b001, 3'b000, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0);
        drv(1'b0, 3'b001, 3'b000, 1'b0); chk("skew_dup_done", 32'(bus.agu_incr), 32'd0);
        drv(1'b0, 3'b100, 3'b000, 1'b0); chk("skew_t3", 32'(bus.agu_incr), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("skew_t4", 32'(bus.agu_incr), 32'd0);
        drv(1'b0, 3'b010, 3'b000, 1'b0); chk("skew_t5", 32'(bus.agu_incr), 32'd0);
        chk("skew_beat_t5", 32'(bus.beat_idx), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("skew_incr_t6", 32'(bus.agu_incr), 32'd1);
        chk("skew_beat_t6", 32'(bus.beat_idx), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b1); chk("skew_kill_busy", 32'(bus.busy), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("skew_kill_idle", 32'(bus.busy), 32'd0);
        chk("skew_kill_vdone", 32'(bus.vector_done), 32'd0);

        // Zero beats, then zero mask
        base_incr = incr_cnt; base_start = start_cnt;
        accept(8'd0, 3'b111);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("zero_nb_vdone", 32'(bus.vector_done), 32'd1);
        chk("zero_nb_start", 32'(bus.if_start), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("zero_nb_idle", 32'(bus.busy), 32'd0);
        accept(8'd3, 3'b000);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("zero_m_vdone", 32'(bus.vector_done), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("zero_m_idle", 32'(bus.busy), 32'd0);
        chk("zero_no_incr", 32'(incr_cnt - base_incr), 32'd0);
        chk("zero_no_start", 32'(start_cnt - base_start), 32'd0);

        // Error during beat 1 with simultaneous completion
        accept(8'd4, 3'b111);
        launch3("err", 3'b111);
        drv(1'b0, 3'b111, 3'b000, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("err_incr0", 32'(bus.agu_incr), 32'd1);
        drv(1'b0, 3'b111, 3'b100, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_no_incr", 32'(bus.agu_incr), 32'd0);
        chk("err_beat", 32'(bus.beat_idx), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("err_idle", 32'(bus.busy), 32'd0);
        chk("err_pulse_end", 32'(bus.err), 32'd0);

        // Kill at beat 2
        accept(8'd4, 3'b111);
        launch3("kill", 3'b111);
        drv(1'b0, 3'b111, 3'b000, 1'b0);
        drv(1'b0, 3'b111, 3'b000, 1'b0); chk("kill_incr0", 32'(bus.agu_incr), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("kill_incr1", 32'(bus.agu_incr), 32'd1);
        chk("kill_beat2", 32'(bus.beat_idx), 32'd2);
        drv(1'b0, 3'b000, 3'b000, 1'b1); chk("kill_err", 32'(bus.err), 32'd0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("kill_idle", 32'(bus.busy), 32'd0);
        chk("kill_vdone", 32'(bus.vector_done), 32'd0);
        chk("kill_err_after", 32'(bus.err), 32'd0);

        // Reset in the middle of RUN, then a normal nb=1 run
        accept(8'd3, 3'b111);
        launch3("rst", 3'b111);
        drv(1'b1, 3'b000, 3'b000, 1'b0); chk("rst_run_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_mid_beat", 32'(bus.beat_idx), 32'd0);
        chk("rst_mid_incr", 32'(bus.agu_incr), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; bus.req = 1'b0;
        accept(8'd1, 3'b111);
        launch3("post", 3'b111);
        drv(1'b0, 3'b111, 3'b000, 1'b0);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("post_incr", 32'(bus.agu_incr), 32'd1);
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("post_vdone", 32'(bus.vector_done), 32'd1);
`ifdef VCVE2_SEQ_PERF_EN
        chk("perf_beats", bus.perf_beats, 32'd1);
`endif
        drv(1'b0, 3'b000, 3'b000, 1'b0); chk("post_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
